// File: rtl/hazard_scoreboard_if.sv
// Decode-side handshake between the pipeline control path and the hazard scoreboard.
// The master drives the instruction in decode; the slave returns stall/flush/forwarding control.
interface hazard_scoreboard_if #(
  parameter int REG_ADDR_W = 5,
  parameter int STAGES     = 3,
  parameter int CNT_W      = 16
);
  localparam int SEL_W = $clog2(STAGES + 1);

  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  id_rs_used;
  logic                  id_rt_used;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_wr_en;
  logic                  id_is_load;
  logic                  branch_taken;
  logic                  stall;
  logic                  flush_ifid;
  logic                  flush_idex;
  logic [SEL_W-1:0]      fwd_rs_sel;
  logic [SEL_W-1:0]      fwd_rt_sel;
  logic [SEL_W-1:0]      occupancy;
  logic [CNT_W-1:0]      stall_count;
  logic [CNT_W-1:0]      flush_count;

  modport master (
    output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_rd, id_wr_en, id_is_load,
           branch_taken,
    input  stall, flush_ifid, flush_idex, fwd_rs_sel, fwd_rt_sel, occupancy,
           stall_count, flush_count
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_rd, id_wr_en, id_is_load,
           branch_taken,
    output stall, flush_ifid, flush_idex, fwd_rs_sel, fwd_rt_sel, occupancy,
           stall_count, flush_count
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Parametrised hazard/forwarding controller: shift-register scoreboard of in-flight
// destinations driving decode stall, per-operand forward select, branch flush and statistics.
module hazard_scoreboard #(
  parameter int REG_ADDR_W = 5,
  parameter int STAGES     = 3,
  parameter int LOAD_LAT   = 2,
  parameter int FWD_EN     = 1,
  parameter int CNT_W      = 16
) (
  input logic                clock,
  input logic                reset,
  hazard_scoreboard_if.slave hz
);
  localparam int SEL_W = $clog2(STAGES + 1);

  logic [STAGES-1:0]     vld_r;
  logic [STAGES-1:0]     ld_r;
  logic [REG_ADDR_W-1:0] rd_r [STAGES];
  logic [SEL_W-1:0]      rs_sel_r;
  logic [SEL_W-1:0]      rt_sel_r;
  logic [SEL_W-1:0]      occ_r;
  logic [CNT_W-1:0]      stall_cnt_r;
  logic [CNT_W-1:0]      flush_cnt_r;

  logic [SEL_W-1:0]      rs_sel_s;
  logic [SEL_W-1:0]      rt_sel_s;
  logic [SEL_W-1:0]      occ_next_s;
  logic [STAGES-1:0]     vld_next_s;
  logic                  hit_s;
  logic                  stall_s;
  logic                  ins_s;
  logic                  m_rs_s;
  logic                  m_rt_s;

  function automatic logic match_f(input logic v, input logic used,
                                   input logic [REG_ADDR_W-1:0] src,
                                   input logic [REG_ADDR_W-1:0] rd);
    return v & used & (src == rd) & (src != {REG_ADDR_W{1'b0}});
  endfunction

  // Hazard detection, youngest-producer forward select and next scoreboard occupancy.
  always_comb begin
    rs_sel_s   = {SEL_W{1'b0}};
    rt_sel_s   = {SEL_W{1'b0}};
    hit_s      = 1'b0;
    m_rs_s     = 1'b0;
    m_rt_s     = 1'b0;
    // Walk oldest to youngest so the lowest matching entry overwrites the select last.
    for (int k = STAGES - 1; k >= 0; k--) begin
      m_rs_s   = match_f(vld_r[k], hz.id_rs_used, hz.id_rs, rd_r[k]);
      m_rt_s   = match_f(vld_r[k], hz.id_rt_used, hz.id_rt, rd_r[k]);
      rs_sel_s = m_rs_s ? SEL_W'(k + 1) : rs_sel_s;
      rt_sel_s = m_rt_s ? SEL_W'(k + 1) : rt_sel_s;
      if (FWD_EN != 0) begin
        hit_s = hit_s | ((m_rs_s | m_rt_s) & ld_r[k] & (k < LOAD_LAT - 1));
      end else begin
        hit_s = hit_s | ((m_rs_s | m_rt_s) & (k < STAGES - 1));
      end
    end
    if (FWD_EN == 0) begin
      rs_sel_s = {SEL_W{1'b0}};
      rt_sel_s = {SEL_W{1'b0}};
    end else begin
      rs_sel_s = rs_sel_s;
      rt_sel_s = rt_sel_s;
    end
    stall_s       = hz.id_valid & ~hz.branch_taken & hit_s & ~reset;
    ins_s         = hz.id_valid & hz.id_wr_en & (hz.id_rd != {REG_ADDR_W{1'b0}}) &
                    ~stall_s & ~hz.branch_taken;
    vld_next_s    = {STAGES{1'b0}};
    vld_next_s[0] = ins_s;
    for (int k = 1; k < STAGES; k++) begin
      vld_next_s[k] = vld_r[k-1];
    end
    occ_next_s = {SEL_W{1'b0}};
    for (int k = 0; k < STAGES; k++) begin
      occ_next_s = occ_next_s + SEL_W'(vld_next_s[k]);
    end
  end

  // Scoreboard shift, ID/EX forward-select latch and saturating statistics.
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_r       <= {STAGES{1'b0}};
      ld_r        <= {STAGES{1'b0}};
      for (int k = 0; k < STAGES; k++) begin
        rd_r[k] <= {REG_ADDR_W{1'b0}};
      end
      rs_sel_r    <= {SEL_W{1'b0}};
      rt_sel_r    <= {SEL_W{1'b0}};
      occ_r       <= {SEL_W{1'b0}};
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      vld_r   <= vld_next_s;
      ld_r[0] <= hz.id_is_load;
      rd_r[0] <= hz.id_rd;
      for (int k = 1; k < STAGES; k++) begin
        ld_r[k] <= ld_r[k-1];
        rd_r[k] <= rd_r[k-1];
      end
      // A stalled or flushed decode slot enters ID/EX as a bubble with no forwarding.
      if (hz.id_valid && !stall_s && !hz.branch_taken) begin
        rs_sel_r <= rs_sel_s;
        rt_sel_r <= rt_sel_s;
      end else begin
        rs_sel_r <= {SEL_W{1'b0}};
        rt_sel_r <= {SEL_W{1'b0}};
      end
      occ_r <= occ_next_s;
      if (stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (hz.branch_taken && (flush_cnt_r != {CNT_W{1'b1}})) begin
        flush_cnt_r <= flush_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign hz.stall       = stall_s;
  assign hz.flush_ifid  = hz.branch_taken;
  assign hz.flush_idex  = hz.branch_taken;
  assign hz.fwd_rs_sel  = rs_sel_r;
  assign hz.fwd_rt_sel  = rt_sel_r;
  assign hz.occupancy   = occ_r;
  assign hz.stall_count = stall_cnt_r;
  assign hz.flush_count = flush_cnt_r;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: forwarding instance, no-forward instance and a
// deep no-forward instance used to drive the stall counter into saturation.
module tb_hazard_scoreboard;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   vecs  = 0;
  int   errs  = 0;

  typedef struct packed { logic [1:0] rs; logic [1:0] rt; } sel_t;
  sel_t sel_q[$];
  sel_t e;

  always #5 clock = ~clock;

  hazard_scoreboard_if ifa ();
  hazard_scoreboard_if ifb ();
  hazard_scoreboard_if #(.STAGES(16)) ifc ();

  hazard_scoreboard dut_a (.clock(clock), .reset(reset), .hz(ifa));
  hazard_scoreboard #(.FWD_EN(0)) dut_b (.clock(clock), .reset(reset), .hz(ifb));
  hazard_scoreboard #(.STAGES(16), .FWD_EN(0)) dut_c (.clock(clock), .reset(reset), .hz(ifc));

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic drive_a(input logic v, input logic [4:0] rs, input logic rsu,
                         input logic [4:0] rt, input logic rtu, input logic [4:0] rd,
                         input logic wr, input logic ld, input logic br);
    ifa.id_valid = v;  ifa.id_rs = rs; ifa.id_rs_used = rsu; ifa.id_rt = rt;
    ifa.id_rt_used = rtu; ifa.id_rd = rd; ifa.id_wr_en = wr; ifa.id_is_load = ld;
    ifa.branch_taken = br;
  endtask

  task automatic drive_b(input logic v, input logic [4:0] rs, input logic rsu,
                         input logic [4:0] rd, input logic wr);
    ifb.id_valid = v; ifb.id_rs = rs; ifb.id_rs_used = rsu; ifb.id_rt = 5'd0;
    ifb.id_rt_used = 1'b0; ifb.id_rd = rd; ifb.id_wr_en = wr; ifb.id_is_load = 1'b0;
    ifb.branch_taken = 1'b0;
  endtask

  task automatic drive_c(input logic v, input logic [4:0] rs, input logic rsu,
                         input logic [4:0] rd, input logic wr);
    ifc.id_valid = v; ifc.id_rs = rs; ifc.id_rs_used = rsu; ifc.id_rt = 5'd0;
    ifc.id_rt_used = 1'b0; ifc.id_rd = rd; ifc.id_wr_en = wr; ifc.id_is_load = 1'b0;
    ifc.branch_taken = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_a(1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0);
    drive_b(1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    drive_c(1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    tick();
    vecs++;
    if (ifa.stall !== 1'b0) begin errs++; $display("FAIL reset_stall: got %b want 0", ifa.stall); end
    vecs++;
    if (ifa.occupancy !== 2'd0 || ifa.fwd_rs_sel !== 2'd0 || ifa.fwd_rt_sel !== 2'd0) begin
      errs++; $display("FAIL reset_state: occ=%0d rs=%0d rt=%0d want 0 0 0",
                       ifa.occupancy, ifa.fwd_rs_sel, ifa.fwd_rt_sel);
    end
    vecs++;
    if (ifa.stall_count !== 16'd0 || ifa.flush_count !== 16'd0) begin
      errs++; $display("FAIL reset_counts: stall=%0d flush=%0d want 0 0",
                       ifa.stall_count, ifa.flush_count);
    end
    reset = 1'b0;
    drive_a(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_alu_raw();
    logic [4:0] t_rs [3] = '{5'd1, 5'd3, 5'd3};
    logic [4:0] t_rt [3] = '{5'd2, 5'd3, 5'd5};
    logic [4:0] t_rd [3] = '{5'd3, 5'd4, 5'd9};
    logic       t_wr [3] = '{1'b1, 1'b1, 1'b0};
    sel_t       t_ex [3] = '{'{2'd0, 2'd0}, '{2'd1, 2'd1}, '{2'd2, 2'd0}};
    for (int i = 0; i < 3; i++) begin
      drive_a(1'b1, t_rs[i], 1'b1, t_rt[i], 1'b1, t_rd[i], t_wr[i], 1'b0, 1'b0);
      sel_q.push_back(t_ex[i]);
      #1;
      vecs++;
      if (ifa.stall !== 1'b0) begin errs++; $display("FAIL alu_stall%0d: got %b want 0", i, ifa.stall); end
      tick();
      e = sel_q.pop_front();
      vecs++;
      if (ifa.fwd_rs_sel !== e.rs || ifa.fwd_rt_sel !== e.rt) begin
        errs++; $display("FAIL alu_sel%0d: got rs=%0d rt=%0d want rs=%0d rt=%0d",
                         i, ifa.fwd_rs_sel, ifa.fwd_rt_sel, e.rs, e.rt);
      end
    end
    vecs++;
    if (ifa.occupancy !== 2'd2) begin errs++; $display("FAIL alu_occ: got %0d want 2", ifa.occupancy); end
    drive_a(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
    vecs++;
    if (ifa.occupancy !== 2'd0) begin errs++; $display("FAIL drain_occ: got %0d want 0", ifa.occupancy); end
  endtask

  task automatic test_load_use();
    logic exp_stall [3] = '{1'b0, 1'b1, 1'b0};
    sel_t t_ex [3] = '{'{2'd0, 2'd0}, '{2'd0, 2'd0}, '{2'd2, 2'd0}};
    for (int i = 0; i < 3; i++) begin
      if (i == 0) drive_a(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
      else        drive_a(1'b1, 5'd5, 1'b1, 5'd0, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
      sel_q.push_back(t_ex[i]);
      #1;
      vecs++;
      if (ifa.stall !== exp_stall[i]) begin
        errs++; $display("FAIL load_stall%0d: got %b want %b", i, ifa.stall, exp_stall[i]);
      end
      tick();
      e = sel_q.pop_front();
      vecs++;
      if (ifa.fwd_rs_sel !== e.rs || ifa.fwd_rt_sel !== e.rt) begin
        errs++; $display("FAIL load_sel%0d: got rs=%0d rt=%0d want rs=%0d rt=%0d",
                         i, ifa.fwd_rs_sel, ifa.fwd_rt_sel, e.rs, e.rt);
      end
    end
    vecs++;
    if (ifa.stall_count !== 16'd1) begin errs++; $display("FAIL load_cnt: got %0d want 1", ifa.stall_count); end
    drive_a(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
  endtask

  task automatic test_reg_zero();
    drive_a(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    tick();
    vecs++;
    if (ifa.occupancy !== 2'd0) begin errs++; $display("FAIL r0_occ: got %0d want 0", ifa.occupancy); end
    drive_a(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    sel_q.push_back('{2'd0, 2'd0});
    #1;
    vecs++;
    if (ifa.stall !== 1'b0) begin errs++; $display("FAIL r0_stall: got %b want 0", ifa.stall); end
    tick();
    e = sel_q.pop_front();
    vecs++;
    if (ifa.fwd_rs_sel !== e.rs || ifa.fwd_rt_sel !== e.rt) begin
      errs++; $display("FAIL r0_sel: got rs=%0d rt=%0d want 0 0", ifa.fwd_rs_sel, ifa.fwd_rt_sel);
    end
    drive_a(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();
  endtask

  task automatic test_flush();
    drive_a(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    tick();
    drive_a(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b1);
    sel_q.push_back('{2'd0, 2'd0});
    #1;
    vecs++;
    if (ifa.stall !== 1'b0 || ifa.flush_ifid !== 1'b1 || ifa.flush_idex !== 1'b1) begin
      errs++; $display("FAIL flush_out: stall=%b ifid=%b idex=%b want 0 1 1",
                       ifa.stall, ifa.flush_ifid, ifa.flush_idex);
    end
    tick();
    e = sel_q.pop_front();
    vecs++;
    if (ifa.fwd_rs_sel !== e.rs || ifa.fwd_rt_sel !== e.rt) begin
      errs++; $display("FAIL flush_sel: got rs=%0d rt=%0d want 0 0", ifa.fwd_rs_sel, ifa.fwd_rt_sel);
    end
    vecs++;
    if (ifa.occupancy !== 2'd1 || ifa.flush_count !== 16'd1 || ifa.stall_count !== 16'd1) begin
      errs++; $display("FAIL flush_state: occ=%0d flush=%0d stall=%0d want 1 1 1",
                       ifa.occupancy, ifa.flush_count, ifa.stall_count);
    end
    drive_a(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    vecs++;
    if (ifa.flush_ifid !== 1'b0 || ifa.flush_idex !== 1'b0) begin
      errs++; $display("FAIL flush_drop: ifid=%b idex=%b want 0 0", ifa.flush_ifid, ifa.flush_idex);
    end
    repeat (3) tick();
  endtask

  task automatic test_no_fwd();
    logic exp_stall [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      if (i == 0) drive_b(1'b1, 5'd0, 1'b0, 5'd7, 1'b1);
      else        drive_b(1'b1, 5'd7, 1'b1, 5'd8, 1'b1);
      sel_q.push_back('{2'd0, 2'd0});
      #1;
      vecs++;
      if (ifb.stall !== exp_stall[i]) begin
        errs++; $display("FAIL nofwd_stall%0d: got %b want %b", i, ifb.stall, exp_stall[i]);
      end
      tick();
      e = sel_q.pop_front();
      vecs++;
      if (ifb.fwd_rs_sel !== e.rs || ifb.fwd_rt_sel !== e.rt) begin
        errs++; $display("FAIL nofwd_sel%0d: got rs=%0d rt=%0d want 0 0", i, ifb.fwd_rs_sel, ifb.fwd_rt_sel);
      end
    end
    vecs++;
    if (ifb.stall_count !== 16'd2 || ifb.occupancy !== 2'd1) begin
      errs++; $display("FAIL nofwd_state: stall_count=%0d occ=%0d want 2 1", ifb.stall_count, ifb.occupancy);
    end
    drive_b(1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    repeat (3) tick();
  endtask

  task automatic test_saturation();
    int          total = 0;
    logic [15:0] exp_cnt;
    for (int p = 0; p < 4370; p++) begin
      drive_c(1'b1, 5'd0, 1'b0, 5'd7, 1'b1);
      tick();
      for (int j = 0; j < 15; j++) begin
        drive_c(1'b1, 5'd7, 1'b1, 5'd0, 1'b0);
        total++;
        if (p == 0 && j == 14) begin
          #1;
          vecs++;
          if (ifc.stall !== 1'b1) begin errs++; $display("FAIL sat_stall: got %b want 1", ifc.stall); end
        end
        tick();
      end
    end
    exp_cnt = (total > 65535) ? 16'hFFFF : 16'(total);
    vecs++;
    if (ifc.stall_count !== exp_cnt) begin
      errs++; $display("FAIL sat_count: got %h want %h", ifc.stall_count, exp_cnt);
    end
    drive_c(1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
  endtask

  task automatic test_reset_mid_stall();
    drive_a(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    tick();
    drive_a(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0);
    #1;
    vecs++;
    if (ifa.stall !== 1'b1) begin errs++; $display("FAIL mid_pre: got %b want 1", ifa.stall); end
    reset = 1'b1;
    #1;
    vecs++;
    if (ifa.stall !== 1'b0) begin errs++; $display("FAIL mid_gate: got %b want 0", ifa.stall); end
    tick();
    reset = 1'b0;
    drive_a(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    vecs++;
    if (ifa.occupancy !== 2'd0 || ifa.stall_count !== 16'd0 || ifa.fwd_rs_sel !== 2'd0) begin
      errs++; $display("FAIL mid_clear: occ=%0d stall_count=%0d rs=%0d want 0 0 0",
                       ifa.occupancy, ifa.stall_count, ifa.fwd_rs_sel);
    end
  endtask

  initial begin
    test_reset();
    test_alu_raw();
    test_load_use();
    test_reg_zero();
    test_flush();
    test_no_fwd();
    test_saturation();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
